// File: rtl/emif_cal_calbus_arbiter_pkg.sv
// Shared definitions for the calbus arbiter: calbus field widths, the FSM
// state type and the helper that sizes requester-index fields.
package emif_cal_calbus_arbiter_pkg;

  localparam int CALBUS_ADDR_W = 20;
  localparam int CALBUS_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } calbus_state_e;

  // Width of a requester index; a single requester still gets one bit.
  function automatic int owner_idx_w(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/emif_cal_calbus_rr_arb.sv
// Combinational round-robin selector.
// Ports:
//   req        in  NUM_REQ  requesters currently asking for the bus
//   last_grant in  OWNER_W  index of the most recently accepted requester
//   grant      out NUM_REQ  one-hot winner (all zero when nobody requests)
// The search begins at last_grant+1 and wraps, so the previous winner has
// the lowest priority in the next round.
module emif_cal_calbus_rr_arb
  import emif_cal_calbus_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int OWNER_W = owner_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] last_grant,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/emif_cal_calbus_arbiter.sv
// Arbitrates NUM_REQ Avalon-style requesters onto a single calbus channel.
// One command is in flight at a time: IDLE accepts, ISSUE drives a one-cycle
// strobe, WAIT_RD counts out RD_LATENCY before returning read data.
// Ports:
//   calbus_clk, calbus_reset_n   clock, synchronous active-low reset
//   req_read/req_write           per-requester command strobes (held until accepted)
//   req_address/req_wdata        packed per-requester address (20b) and data (32b)
//   req_waitrequest              low only in the accepting IDLE cycle of the winner
//   req_rdata/req_rdata_valid    shared read data, one-cycle pulse to the owner
//   calbus_read/calbus_write     one-cycle strobes toward the calbus
//   calbus_address/calbus_wdata  registered command fields, held between strobes
//   calbus_rdata                 calbus read return
//   busy                         FSM outside IDLE
//   proto_err                    sticky: a winner raised read and write together
module emif_cal_calbus_arbiter
  import emif_cal_calbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int RD_LATENCY = 2
) (
  input  logic                             calbus_clk,
  input  logic                             calbus_reset_n,
  input  logic [NUM_REQ-1:0]               req_read,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*CALBUS_ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*CALBUS_DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]               req_waitrequest,
  output logic [CALBUS_DATA_W-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]               req_rdata_valid,
  output logic                             calbus_read,
  output logic                             calbus_write,
  output logic [CALBUS_ADDR_W-1:0]         calbus_address,
  output logic [CALBUS_DATA_W-1:0]         calbus_wdata,
  input  logic [CALBUS_DATA_W-1:0]         calbus_rdata,
  output logic                             busy,
  output logic                             proto_err
);

  localparam int OWNER_W = owner_idx_w(NUM_REQ);
  localparam int CNT_W   = $clog2(RD_LATENCY + 1);
  localparam logic [OWNER_W-1:0] LAST_INIT = OWNER_W'(NUM_REQ - 1);

  calbus_state_e             state;
  logic [OWNER_W-1:0]        last_grant;
  logic [OWNER_W-1:0]        owner;
  logic                      op_wr;
  logic [CNT_W-1:0]          rd_cnt;
  logic [CALBUS_ADDR_W-1:0]  addr_q;
  logic [CALBUS_DATA_W-1:0]  wdata_q;
  logic [CALBUS_DATA_W-1:0]  rdata_p0;
  logic [NUM_REQ-1:0]        rdata_vld_p0;
  logic                      proto_err_q;

  logic [NUM_REQ-1:0]        grant;
  logic                      accept;
  logic [OWNER_W-1:0]        win_idx;
  logic [CALBUS_ADDR_W-1:0]  win_addr;
  logic [CALBUS_DATA_W-1:0]  win_wdata;
  logic                      win_rd;
  logic                      win_wr;
  logic [NUM_REQ-1:0]        owner_oh;

  emif_cal_calbus_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
    .req        (req_read | req_write),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Mux the winning requester's command fields out of the packed buses.
  always_comb begin
    win_idx   = '0;
    win_addr  = '0;
    win_wdata = '0;
    win_rd    = 1'b0;
    win_wr    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_idx   = OWNER_W'(i);
        win_addr  = req_address[i*CALBUS_ADDR_W +: CALBUS_ADDR_W];
        win_wdata = req_wdata[i*CALBUS_DATA_W +: CALBUS_DATA_W];
        win_rd    = req_read[i];
        win_wr    = req_write[i];
      end
    end
  end

  assign accept   = (state == ST_IDLE) && (|grant);
  assign owner_oh = NUM_REQ'(1) << owner;

  // Waitrequest is forced high during reset even though the FSM only
  // reacts to reset on the clock edge.
  assign req_waitrequest = ~(grant & {NUM_REQ{calbus_reset_n && (state == ST_IDLE)}});

  always_ff @(posedge calbus_clk) begin
    if (!calbus_reset_n) begin
      state        <= ST_IDLE;
      last_grant   <= LAST_INIT;
      owner        <= '0;
      op_wr        <= 1'b0;
      rd_cnt       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_p0     <= '0;
      rdata_vld_p0 <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      rdata_vld_p0 <= '0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_ISSUE;
            last_grant <= win_idx;
            owner      <= win_idx;
            op_wr      <= win_wr;   // read+write resolves to a write
            addr_q     <= win_addr;
            wdata_q    <= win_wdata;
            if (win_rd && win_wr) proto_err_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (op_wr) begin
            state <= ST_IDLE;
          end else begin
            state  <= ST_WAIT_RD;
            rd_cnt <= CNT_W'(RD_LATENCY);
          end
        end
        ST_WAIT_RD: begin
          rd_cnt <= rd_cnt - 1'b1;
          // Last wait cycle is strobe+RD_LATENCY: capture and return to IDLE
          // so the next command can be accepted alongside the valid pulse.
          if (rd_cnt == CNT_W'(1)) begin
            state        <= ST_IDLE;
            rdata_p0     <= calbus_rdata;
            rdata_vld_p0 <= owner_oh;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign calbus_read     = (state == ST_ISSUE) && !op_wr;
  assign calbus_write    = (state == ST_ISSUE) && op_wr;
  assign calbus_address  = addr_q;
  assign calbus_wdata    = wdata_q;
  assign req_rdata       = rdata_p0;
  assign req_rdata_valid = rdata_vld_p0;
  assign busy            = (state != ST_IDLE);
  assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_emif_cal_calbus_arbiter.sv
module tb_emif_cal_calbus_arbiter;

  localparam int NUM_REQ    = 2;
  localparam int RD_LATENCY = 2;

  logic                    calbus_clk = 1'b0;
  logic                    calbus_reset_n;
  logic [NUM_REQ-1:0]      req_read;
  logic [NUM_REQ-1:0]      req_write;
  logic [NUM_REQ*20-1:0]   req_address;
  logic [NUM_REQ*32-1:0]   req_wdata;
  logic [NUM_REQ-1:0]      req_waitrequest;
  logic [31:0]             req_rdata;
  logic [NUM_REQ-1:0]      req_rdata_valid;
  logic                    calbus_read;
  logic                    calbus_write;
  logic [19:0]             calbus_address;
  logic [31:0]             calbus_wdata;
  logic [31:0]             calbus_rdata;
  logic                    busy;
  logic                    proto_err;

  always #5 calbus_clk = ~calbus_clk;

  emif_cal_calbus_arbiter #(.NUM_REQ(NUM_REQ), .RD_LATENCY(RD_LATENCY)) dut (
    .calbus_clk      (calbus_clk),
    .calbus_reset_n  (calbus_reset_n),
    .req_read        (req_read),
    .req_write       (req_write),
    .req_address     (req_address),
    .req_wdata       (req_wdata),
    .req_waitrequest (req_waitrequest),
    .req_rdata       (req_rdata),
    .req_rdata_valid (req_rdata_valid),
    .calbus_read     (calbus_read),
    .calbus_write    (calbus_write),
    .calbus_address  (calbus_address),
    .calbus_wdata    (calbus_wdata),
    .calbus_rdata    (calbus_rdata),
    .busy            (busy),
    .proto_err       (proto_err)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [19:0] addr;
    logic [31:0] data;
    bit          frc;
    logic [31:0] fdata;
  } cmd_t;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [19:0] addr;
    logic [31:0] data;
  } strobe_t;

  typedef struct {
    int                 cyc;
    logic [NUM_REQ-1:0] oh;
    logic [31:0]        data;
  } rv_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          checks_on = 0;
  bit          rst_drive = 0;
  bit          rand_on   = 0;

  // Reference model: per-requester command queues, a "bus free from" cycle,
  // the last granted index and the sticky error bit.
  cmd_t        cq [NUM_REQ][$];
  strobe_t     sq [$];
  rv_t         rq [$];
  logic [31:0] rd_force [int];
  int          m_free = 0;
  int          m_last = NUM_REQ - 1;
  bit          perr_cur = 0;
  bit          perr_next = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_val(input int c);
    if (rd_force.exists(c)) return rd_force[c];
    return (32'(c) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic drive();
    calbus_reset_n = rst_drive;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (cq[r].size() > 0) begin
        req_read[r]            = cq[r][0].rd;
        req_write[r]           = cq[r][0].wr;
        req_address[r*20 +: 20] = cq[r][0].addr;
        req_wdata[r*32 +: 32]   = cq[r][0].data;
      end else begin
        req_read[r]            = 1'b0;
        req_write[r]           = 1'b0;
        req_address[r*20 +: 20] = 20'($urandom());
        req_wdata[r*32 +: 32]   = $urandom();
      end
    end
    calbus_rdata = rd_val(cyc);
  endtask

  task automatic accept_cmd(input int w);
    cmd_t    c;
    strobe_t s;
    rv_t     v;
    c = cq[w].pop_front();
    m_last = w;
    if (c.rd && c.wr) perr_next = 1'b1;
    s.cyc  = cyc + 1;
    s.wr   = c.wr;
    s.addr = c.addr;
    s.data = c.data;
    sq.push_back(s);
    if (c.wr) begin
      m_free = cyc + 2;
    end else begin
      if (c.frc) rd_force[cyc + 1 + RD_LATENCY] = c.fdata;
      v.cyc  = cyc + RD_LATENCY + 2;
      v.oh   = NUM_REQ'(1) << w;
      v.data = rd_val(cyc + 1 + RD_LATENCY);
      rq.push_back(v);
      m_free = cyc + RD_LATENCY + 2;
    end
  endtask

  task automatic push_cmd(input int r, input bit rd, input bit wr, input logic [19:0] a,
                          input logic [31:0] d, input bit frc, input logic [31:0] fd);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.addr = a; c.data = d; c.frc = frc; c.fdata = fd;
    cq[r].push_back(c);
  endtask

  task automatic model_step();
    logic [NUM_REQ-1:0] exp_wr;
    int                 w;
    bit                 idle;
    idle = (cyc >= m_free);
    if (checks_on) begin
      chk("busy", 64'(busy), 64'(!idle));
      chk("proto_err", 64'(proto_err), 64'(perr_cur));
    end
    exp_wr = '1;
    w = -1;
    if (!rst_drive) begin
      // Anything scheduled after this cycle is dropped by the reset edge.
      while (sq.size() > 0 && sq[sq.size()-1].cyc > cyc) void'(sq.pop_back());
      while (rq.size() > 0 && rq[rq.size()-1].cyc > cyc) void'(rq.pop_back());
      m_free    = cyc + 1;
      m_last    = NUM_REQ - 1;
      perr_next = 1'b0;
    end else if (idle) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int r;
        r = (m_last + k) % NUM_REQ;
        if (w < 0 && cq[r].size() > 0) w = r;
      end
      if (w >= 0) begin
        exp_wr[w] = 1'b0;
        accept_cmd(w);
      end
    end
    if (checks_on) chk("waitrequest", 64'(req_waitrequest), 64'(exp_wr));
    perr_cur = perr_next;
    if (rand_on) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (cq[r].size() < 3 && $urandom_range(0, 99) < 35) begin
          int op;
          op = $urandom_range(0, 19);
          push_cmd(r, op >= 9, op < 9 || op == 19, 20'($urandom()), $urandom(), 1'b0, 32'h0);
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge calbus_clk);
    cyc++;
    #1;
    drive();
    @(negedge calbus_clk);
    model_step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_reset_vals();
    chk("rst_calbus_read", 64'(calbus_read), 64'(0));
    chk("rst_calbus_write", 64'(calbus_write), 64'(0));
    chk("rst_calbus_address", 64'(calbus_address), 64'(0));
    chk("rst_calbus_wdata", 64'(calbus_wdata), 64'(0));
    chk("rst_req_rdata", 64'(req_rdata), 64'(0));
    chk("rst_req_rdata_valid", 64'(req_rdata_valid), 64'(0));
    chk("rst_proto_err", 64'(proto_err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_waitrequest", 64'(req_waitrequest), 64'({NUM_REQ{1'b1}}));
  endtask

  task automatic do_reset();
    rst_drive = 1'b0;
    run(2);
    check_reset_vals();
    rst_drive = 1'b1;
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT presents a strobe
  // or a read-return pulse.
  always @(negedge calbus_clk) begin : monitor
    strobe_t s;
    rv_t     v;
    if (checks_on) begin
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        s = sq.pop_front();
        chk("strobe_missing", 64'(0), 64'(s.cyc));
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        v = rq.pop_front();
        chk("rvalid_missing", 64'(0), 64'(v.cyc));
      end
      if (calbus_read === 1'b1 || calbus_write === 1'b1) begin
        if (sq.size() == 0) begin
          chk("unexpected_strobe", 64'({calbus_read, calbus_write}), 64'(0));
        end else begin
          s = sq.pop_front();
          chk("strobe_cycle", 64'(cyc), 64'(s.cyc));
          chk("strobe_op", 64'({calbus_read, calbus_write}), 64'(s.wr ? 2'b01 : 2'b10));
          chk("strobe_addr", 64'(calbus_address), 64'(s.addr));
          if (s.wr) chk("strobe_wdata", 64'(calbus_wdata), 64'(s.data));
        end
      end
      if (req_rdata_valid !== '0) begin
        if (rq.size() == 0) begin
          chk("unexpected_rvalid", 64'(req_rdata_valid), 64'(0));
        end else begin
          v = rq.pop_front();
          chk("rvalid_cycle", 64'(cyc), 64'(v.cyc));
          chk("rvalid_owner", 64'(req_rdata_valid), 64'(v.oh));
          chk("rdata", 64'(req_rdata), 64'(v.data));
        end
      end
    end
  end

  initial begin
    calbus_reset_n = 1'b0;
    req_read       = '0;
    req_write      = '0;
    req_address    = '0;
    req_wdata      = '0;
    calbus_rdata   = '0;

    rst_drive = 1'b0;
    cycle();
    checks_on = 1'b1;
    cycle();
    check_reset_vals();
    rst_drive = 1'b1;

    // Single write from requester 0
    push_cmd(0, 1'b0, 1'b1, 20'h00010, 32'hDEAD_BEEF, 1'b0, 32'h0);
    run(5);

    // Single read from requester 1, known return data
    push_cmd(1, 1'b1, 1'b0, 20'h00020, 32'h0, 1'b1, 32'h1234_5678);
    run(8);
    for (int i = 0; i < 3; i++) begin
      chk("rdata_hold", 64'(req_rdata), 64'(32'h1234_5678));
      cycle();
    end

    // Fairness from reset: both requesters hold continuous writes
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_cmd(0, 1'b0, 1'b1, 20'(32'h00100 + i), $urandom(), 1'b0, 32'h0);
      push_cmd(1, 1'b0, 1'b1, 20'(32'h00200 + i), $urandom(), 1'b0, 32'h0);
    end
    run(20);

    // Reset one cycle after a read strobe drops the read
    push_cmd(0, 1'b1, 1'b0, 20'h00040, 32'h0, 1'b0, 32'h0);
    cycle();            // acceptance
    cycle();            // strobe
    rst_drive = 1'b0;
    run(2);
    check_reset_vals();
    rst_drive = 1'b1;
    push_cmd(1, 1'b0, 1'b1, 20'h00050, 32'hCAFE_F00D, 1'b0, 32'h0);
    run(6);

    // Read and write together
    push_cmd(0, 1'b1, 1'b1, 20'h00030, 32'hA5A5_1234, 1'b0, 32'h0);
    run(10);
    chk("proto_err_sticky", 64'(proto_err), 64'(1));

    // Back-to-back reads from one requester
    push_cmd(0, 1'b1, 1'b0, 20'h00060, 32'h0, 1'b0, 32'h0);
    push_cmd(0, 1'b1, 1'b0, 20'h00061, 32'h0, 1'b0, 32'h0);
    run(12);

    // Randomized traffic
    rand_on = 1'b1;
    run(1500);
    rand_on = 1'b0;
    run(40);
    chk("strobes_drained", 64'(sq.size()), 64'(0));
    chk("rvalids_drained", 64'(rq.size()), 64'(0));

    do_reset();
    run(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
